// File: rtl/snake_game_engine.sv
// rtl/snake_game_engine.sv - snake game logic: body list, steering, food placement, win/lose
//
// Purpose:
//   Game-logic stage feeding the snake renderer. Keeps the snake body as an
//   ordered list of 8-bit cell indices ({row[3:0], col[3:0]}) on a 16x16 grid,
//   entry 0 being the head. The snake advances one cell per Tick, steers from
//   the four direction buttons, grows on food, places new food from a free
//   running LFSR and reports idle/run/win/lose as a one-hot status.
//
// Optional feature:
//   SNAKE_WRAP_EN - when defined the grid edges wrap around instead of
//                   causing a loss; self collision still loses.
//
// Ports:
//   Clk        in   system clock
//   Reset      in   synchronous, active-high reset
//   Tick       in   one-Clk move strobe (game speed)
//   Start      in   begins/restarts a game from idle, win or lose
//   BtnU/D/L/R in   level direction requests (already debounced)
//   Locations  out  MAX_LEN*8 body cells, entry i at [8i+7:8i], entry 0 = head
//   Length     out  live segment count
//   Food       out  food cell index
//   Qi/Qr/Qw/Ql out one-hot status: idle, run, win, lose

module snake_game_engine #(
  parameter int         MAX_LEN   = 8,
  parameter int         INIT_LEN  = 3,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Tick,
  input  logic                 Start,
  input  logic                 BtnU,
  input  logic                 BtnD,
  input  logic                 BtnL,
  input  logic                 BtnR,
  output logic [MAX_LEN*8-1:0] Locations,
  output logic [3:0]           Length,
  output logic [7:0]           Food,
  output logic                 Qi,
  output logic                 Qr,
  output logic                 Qw,
  output logic                 Ql
);

  localparam logic [3:0] MAX_LEN_W  = 4'(MAX_LEN);
  localparam logic [3:0] INIT_LEN_W = 4'(INIT_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_PLACE,
    S_WIN,
    S_LOSE
  } state_t;

  typedef enum logic [1:0] {
    DIR_U,
    DIR_D,
    DIR_L,
    DIR_R
  } dir_t;

  state_t     state;
  dir_t       dir;
  dir_t       pend;
  dir_t       base_dir;
  dir_t       req_dir;
  logic       req_ok;
  logic [7:0] body [MAX_LEN];
  logic [7:0] lfsr;
  logic [7:0] lfsr_next;
  logic [3:0] head_row;
  logic [3:0] head_col;
  logic [7:0] next_head;
  logic       hit_wall;
  logic       eat;
  logic       self_hit;
  logic       food_hit;
  logic [3:0] grow_len;

  // Fibonacci LFSR, taps 8,6,5,4; free-running so food depends on player timing
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  assign head_row = body[0][7:4];
  assign head_col = body[0][3:0];
  assign eat      = (next_head == Food);
  assign grow_len = Length + 4'd1;

  // The move taken on a Tick uses the pending direction, which commits on that Tick.
  // 4-bit row/col arithmetic wraps naturally, which is exactly the wrap-mode result.
  always_comb begin
    next_head = body[0];
    hit_wall  = 1'b0;
    case (pend)
      DIR_U: begin
        next_head = {head_row - 4'd1, head_col};
        hit_wall  = (head_row == 4'd0);
      end
      DIR_D: begin
        next_head = {head_row + 4'd1, head_col};
        hit_wall  = (head_row == 4'd15);
      end
      DIR_L: begin
        next_head = {head_row, head_col - 4'd1};
        hit_wall  = (head_col == 4'd0);
      end
      default: begin
        next_head = {head_row, head_col + 4'd1};
        hit_wall  = (head_col == 4'd15);
      end
    endcase
`ifdef SNAKE_WRAP_EN
    hit_wall = 1'b0;
`endif
  end

  // The tail cell is free to enter unless this move eats, since the tail vacates.
  always_comb begin
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(Length) && body[i] == next_head &&
          !(i == int'(Length) - 1 && !eat)) begin
        self_hit = 1'b1;
      end
    end
  end

  always_comb begin
    food_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(Length) && body[i] == lfsr) begin
        food_hit = 1'b1;
      end
    end
  end

  // Reversal is judged against the direction in force after this edge, so a
  // button on a Tick cycle cannot queue a U-turn behind the committing move.
  always_comb begin
    base_dir = Tick ? pend : dir;
    req_ok   = 1'b0;
    req_dir  = pend;
    if (BtnU && base_dir != DIR_D) begin
      req_ok  = 1'b1;
      req_dir = DIR_U;
    end else if (BtnD && base_dir != DIR_U) begin
      req_ok  = 1'b1;
      req_dir = DIR_D;
    end else if (BtnL && base_dir != DIR_R) begin
      req_ok  = 1'b1;
      req_dir = DIR_L;
    end else if (BtnR && base_dir != DIR_L) begin
      req_ok  = 1'b1;
      req_dir = DIR_R;
    end
  end

  always_comb begin
    Locations = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      Locations[8*i +: 8] = body[i];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= S_IDLE;
      Qi     <= 1'b1;
      Qr     <= 1'b0;
      Qw     <= 1'b0;
      Ql     <= 1'b0;
      Length <= 4'd0;
      Food   <= 8'h00;
      dir    <= DIR_R;
      pend   <= DIR_R;
      lfsr   <= LFSR_SEED;
      for (int i = 0; i < MAX_LEN; i++) begin
        body[i] <= 8'h00;
      end
    end else begin
      lfsr <= lfsr_next;
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (Start) begin
            state <= S_INIT;
            Qi    <= 1'b0;
            Qr    <= 1'b0;
            Qw    <= 1'b0;
            Ql    <= 1'b0;
          end
        end

        S_INIT: begin
          for (int k = 0; k < MAX_LEN; k++) begin
            body[k] <= (k < INIT_LEN) ? 8'(136 - k) : 8'h00;
          end
          Length <= INIT_LEN_W;
          dir    <= DIR_R;
          pend   <= DIR_R;
          Food   <= 8'h8C;
          state  <= S_RUN;
          Qr     <= 1'b1;
        end

        S_RUN: begin
          if (req_ok) begin
            pend <= req_dir;
          end
          if (Tick) begin
            dir <= pend;
            if (hit_wall || self_hit) begin
              state <= S_LOSE;
              Qr    <= 1'b0;
              Ql    <= 1'b1;
            end else begin
              body[0] <= next_head;
              for (int i = 1; i < MAX_LEN; i++) begin
                body[i] <= body[i-1];
              end
              if (eat) begin
                Length <= grow_len;
                Qr     <= 1'b0;
                if (grow_len == MAX_LEN_W) begin
                  state <= S_WIN;
                  Qw    <= 1'b1;
                end else begin
                  state <= S_PLACE;
                end
              end
            end
          end
        end

        // Retry every cycle until the LFSR lands on a free cell; Ticks here are dropped.
        S_PLACE: begin
          if (!food_hit) begin
            Food  <= lfsr;
            state <= S_RUN;
            Qr    <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          Qi    <= 1'b1;
          Qr    <= 1'b0;
          Qw    <= 1'b0;
          Ql    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_game_engine.sv
// tb/tb_snake_game_engine.sv - scoreboard bench for snake_game_engine against a list-based game model

module tb_snake_game_engine;

  localparam int MAX_LEN = 8;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        tick  = 1'b0;
  logic        start = 1'b0;
  logic        bu    = 1'b0;
  logic        bd    = 1'b0;
  logic        bl    = 1'b0;
  logic        br    = 1'b0;
  logic [63:0] locs;
  logic [3:0]  len;
  logic [7:0]  food;
  logic        qi, qr, qw, ql;

  snake_game_engine #(.MAX_LEN(MAX_LEN), .INIT_LEN(3), .LFSR_SEED(8'hA5)) dut (
    .Clk(clk), .Reset(rst), .Tick(tick), .Start(start),
    .BtnU(bu), .BtnD(bd), .BtnL(bl), .BtnR(br),
    .Locations(locs), .Length(len), .Food(food),
    .Qi(qi), .Qr(qr), .Qw(qw), .Ql(ql)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  q;
    logic [3:0]  len;
    logic [7:0]  food;
    logic [63:0] loc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Game model: body as a list, directions as (row, col) deltas
  string      m_st   = "IDLE";
  int         m_len  = 0;
  logic [7:0] m_food = 8'h00;
  logic [7:0] m_body[$];
  int         m_dr = 0, m_dc = 1, m_pr = 0, m_pc = 1;
  logic [7:0] m_lfsr = 8'hA5;
  int         btn_dr[4] = '{-1, 1, 0, 0};
  int         btn_dc[4] = '{0, 0, -1, 1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic bit occupied(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) if (m_body[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [8:0] step_cell(input logic [7:0] h, input int dr, input int dc);
    int r, c;
    bit wall;
    r = int'(h[7:4]) + dr;
    c = int'(h[3:0]) + dc;
    wall = (r < 0) || (r > 15) || (c < 0) || (c > 15);
`ifdef SNAKE_WRAP_EN
    wall = 1'b0;
    r = (r + 16) % 16;
    c = (c + 16) % 16;
`endif
    return {wall, 8'(r * 16 + c)};
  endfunction

  task automatic model_step(input bit rs, input bit tk, input bit st, input bit [3:0] btn);
    logic [7:0] cand;
    logic [8:0] s;
    bit eat, hit, was_run;
    if (rs) begin
      m_st = "IDLE"; m_len = 0; m_food = 8'h00;
      m_body = {};
      repeat (MAX_LEN) m_body.push_back(8'h00);
      m_dr = 0; m_dc = 1; m_pr = 0; m_pc = 1;
      m_lfsr = 8'hA5;
      return;
    end
    cand = m_lfsr;
    m_lfsr = lfsr_step(m_lfsr);
    was_run = (m_st == "RUN");
    if (m_st == "IDLE" || m_st == "WIN" || m_st == "LOSE") begin
      if (st) m_st = "INIT";
    end else if (m_st == "INIT") begin
      m_body = {8'h88, 8'h87, 8'h86, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      m_len = 3; m_food = 8'h8C;
      m_dr = 0; m_dc = 1; m_pr = 0; m_pc = 1;
      m_st = "RUN";
    end else if (m_st == "RUN") begin
      if (tk) begin
        m_dr = m_pr; m_dc = m_pc;
        s = step_cell(m_body[0], m_dr, m_dc);
        eat = (s[7:0] == m_food);
        hit = !s[8] && occupied(s[7:0], eat ? m_len : m_len - 1);
        if (s[8] || hit) m_st = "LOSE";
        else begin
          m_body.push_front(s[7:0]);
          void'(m_body.pop_back());
          if (eat) begin
            m_len++;
            m_st = (m_len == MAX_LEN) ? "WIN" : "PLACE";
          end
        end
      end
    end else if (m_st == "PLACE") begin
      if (!occupied(cand, m_len)) begin
        m_food = cand;
        m_st = "RUN";
      end
    end
    if (was_run) begin
      for (int k = 0; k < 4; k++) begin
        if (btn[k] && !(btn_dr[k] == -m_dr && btn_dc[k] == -m_dc)) begin
          m_pr = btn_dr[k]; m_pc = btn_dc[k];
          break;
        end
      end
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.q    = {m_st == "IDLE", m_st == "RUN", m_st == "WIN", m_st == "LOSE"};
    e.len  = 4'(m_len);
    e.food = m_food;
    e.loc  = '0;
    for (int i = 0; i < MAX_LEN; i++) e.loc[8*i +: 8] = m_body[i];
    return e;
  endfunction

  // btn bit 0 = U, 1 = D, 2 = L, 3 = R
  task automatic cyc(input bit rs, input bit tk, input bit st, input bit [3:0] btn);
    @(negedge clk);
    rst = rs; tick = tk; start = st;
    {br, bl, bd, bu} = btn;
    model_step(rs, tk, st, btn);
    sb.push_back(snap());
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic wait_run();
    int n = 0;
    while (!qr && n < 300) begin
      idle();
      n++;
    end
    if (!qr) begin
      checks++;
      errors++;
      $display("FAIL wait_run: Qr got 0 expected 1 within 300 cycles");
    end
  endtask

  task automatic tick_run();
    wait_run();
    cyc(1'b0, 1'b1, 1'b0, 4'b0000);
  endtask

  task automatic restart();
    cyc(1'b1, 1'b0, 1'b0, 4'b0000);
    cyc(1'b0, 1'b0, 1'b1, 4'b0000);
    idle();
  endtask

  // Greedy steering toward food from the model's own view of the board
  function automatic int pick();
    int best = -1, bdist = 1000, dr, dc;
    logic [8:0] s;
    for (int k = 0; k < 4; k++) begin
      if (btn_dr[k] == -m_dr && btn_dc[k] == -m_dc) continue;
      s = step_cell(m_body[0], btn_dr[k], btn_dc[k]);
      if (s[8] || occupied(s[7:0], m_len - 1)) continue;
      dr = int'(m_food[7:4]) - int'(s[7:4]);
      dc = int'(m_food[3:0]) - int'(s[3:0]);
      if (dr < 0) dr = -dr;
      if (dc < 0) dc = -dc;
      if (dr + dc < bdist) begin
        bdist = dr + dc;
        best = k;
      end
    end
    return best;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("q_onehot", {qi, qr, qw, ql}, e.q);
        check("length", len, e.len);
        check("food", food, e.food);
        check("locations", locs, e.loc);
      end
    end
  end

  initial begin : driver
    logic [63:0] saved;
    logic [7:0]  food1, sfood;
    logic [3:0]  row, slen;
    int          n, k;

    repeat (3) cyc(1'b1, 1'b0, 1'b0, 4'b0000);
    check("reset_qi", qi, 1);
    check("reset_len", len, 0);
    check("reset_food", food, 0);
    check("reset_locs", locs, 0);

    cyc(1'b0, 1'b0, 1'b1, 4'b0000);
    idle();
    check("start_qr", qr, 1);
    check("start_len", len, 3);
    check("start_locs", locs[23:0], 24'h868788);
    check("start_food", food, 8'h8C);

    repeat (4) tick_run();
    check("eat_head", locs[7:0], 8'h8C);
    check("eat_len", len, 4);
    check("eat_place_qr", qr, 0);
    wait_run();
    food1 = food;
    check("food_not_on_body", (food inside {8'h8C, 8'h8B, 8'h8A, 8'h89}) ? 1 : 0, 0);

    restart();
    cyc(1'b0, 1'b0, 1'b0, 4'b0100);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000);
    check("btnl_reverse_ignored", locs[7:0], 8'h89);
    cyc(1'b0, 1'b0, 1'b0, 4'b0001);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000);
    check("btnu_turn", locs[7:0], 8'h79);

    cyc(1'b0, 1'b0, 1'b0, 4'b1000);
    n = 0;
    while (locs[3:0] != 4'hF && n < 20) begin
      tick_run();
      n++;
    end
    check("reach_col15", locs[3:0], 4'hF);
    saved = locs;
    row = locs[7:4];
    tick_run();
`ifdef SNAKE_WRAP_EN
    check("wrap_head", locs[7:0], {row, 4'h0});
`else
    check("wall_lose", ql, 1);
    check("wall_body_frozen", locs, saved);
`endif

    restart();
    n = 0;
    while (!qw && n < 4000) begin
      if (m_st == "LOSE") begin
        cyc(1'b0, 1'b0, 1'b1, 4'b0000);
        idle();
      end else if (m_st == "RUN") begin
        k = pick();
        if (k >= 0 && (btn_dr[k] != m_pr || btn_dc[k] != m_pc))
          cyc(1'b0, 1'b0, 1'b0, 4'(1 << k));
        cyc(1'b0, 1'b1, 1'b0, 4'b0000);
      end else begin
        idle();
      end
      n++;
    end
    check("win_qw", qw, 1);
    check("win_len", len, 8);
    saved = locs; slen = len; sfood = food;
    cyc(1'b0, 1'b1, 1'b0, 4'b0000);
    cyc(1'b0, 1'b0, 1'b0, 4'b0001);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000);
    check("win_frozen_locs", locs, saved);
    check("win_frozen_len", len, slen);
    check("win_frozen_food", food, sfood);
    check("win_frozen_qw", qw, 1);

    restart();
    repeat (4) tick_run();
    cyc(1'b1, 1'b0, 1'b0, 4'b0000);
    check("place_reset_qi", qi, 1);
    check("place_reset_len", len, 0);
    check("place_reset_food", food, 0);
    check("place_reset_locs", locs, 0);
    cyc(1'b0, 1'b0, 1'b1, 4'b0000);
    idle();
    repeat (4) tick_run();
    wait_run();
    check("lfsr_reseeded_food", food, food1);

    cyc(1'b1, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 3000; i++) begin
      bit rs, st, tk;
      bit [3:0] btn;
      rs  = ($urandom % 400) == 0;
      st  = ($urandom % 30) == 0;
      tk  = ($urandom % 3) == 0;
      btn = 4'b0000;
      if (!tk && ($urandom % 3) == 0) btn = 4'(1 << ($urandom % 4));
      cyc(rs, tk, st, btn);
    end

    #10;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_game_engine.md
Name: snake_game_engine

Overview:
- Game-logic stage directly upstream of snake_controller; produces the Food, Length, Locations, Qw and Ql signals it renders.
- Holds snake body as an ordered list of 8-bit cell indices on a 16x16 grid: index = {row[3:0], col[3:0]}, so col = idx%16, row = idx/16. Entry 0 is the head.
- Advances one cell per Tick strobe. Handles steering, growth, food placement via internal LFSR, and win/lose detection.

Parameters:
- MAX_LEN, 8, body capacity; reaching it wins.
- INIT_LEN, 3, length after start (2..MAX_LEN-1).
- LFSR_SEED, 8'hA5, nonzero food-LFSR reset value.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Tick  in  1  one-Clk move strobe (game speed).
- Start  in  1  level; begins/restarts game from IDLE/WIN/LOSE.
- BtnU, BtnD, BtnL, BtnR  in  1 each  direction requests (debounced, level).
- Locations  out  MAX_LEN*8  body cells; entry i at bits [8i+7:8i]; entry 0 = head.
- Length  out  4  live segment count.
- Food  out  8  food cell index.
- Qi, Qr, Qw, Ql  out  1 each  one-hot state: idle, run, win, lose.

Behaviour:
- Reset (Clk edge with Reset=1): state IDLE (Qi=1, others 0); Length=0; Food=8'h00; all Locations=8'h00; dir=RIGHT; LFSR=LFSR_SEED.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Steps every Clk in all states, so food depends on human timing.
- IDLE/WIN/LOSE -> Start=1 -> INIT (one cycle):
  - Locations[k]=8'h88-k for k<INIT_LEN; others 8'h00.
  - Length=INIT_LEN, dir=RIGHT, Food=8'h8C.
  - Then RUN.
- RUN, steering: sampled every Clk into pending dir. Priority U>D>L>R. A request opposite the current dir is ignored. Pending dir commits to dir on Tick.
- RUN, on Tick:
  - Compute next head from head and committed dir: col±1 or row±1.
  - Wall: col 15 moving R, col 0 moving L, row 0 moving U, or row 15 moving D -> LOSE. Body unchanged.
  - eat = (next == Food).
  - Self hit: next equals any Locations[i] for i<Length, excluding i=Length-1 when eat=0 (tail vacates) -> LOSE.
  - Otherwise shift: Locations[i]<=Locations[i-1] for i=1..MAX_LEN-1; Locations[0]<=next.
  - If eat: Length<=Length+1. If new Length==MAX_LEN -> WIN, else -> PLACE.
  - Vacated entries at index >= Length are don't-care to the renderer but must be driven deterministically by the shift.
- PLACE (food search): each Clk, candidate = LFSR value.
  - Candidate equal to any live segment (i<Length) -> stay, retry next Clk.
  - Otherwise Food<=candidate, -> RUN.
  - Food holds its old value throughout PLACE.
  - A Tick arriving in PLACE is dropped (not queued).
- LFSR never produces 8'h00, so cell 0 is never chosen as food. This is accepted.
- WIN/LOSE: body, Length, Food frozen; Tick and buttons ignored.
- Reset mid-game (any state): immediate return to reset values on that edge. Reset has priority over Start and Tick.
- Length never exceeds MAX_LEN. Outputs registered; 1-cycle latency from Tick to updated Locations.

Optional Feature:
- Macro SNAKE_WRAP_EN.
- Defined: walls wrap. col 15 + R -> col 0, row 0 + U -> row 15, etc. Wall loss is removed; self collision still loses.
- Undefined: wall contact -> LOSE as above.

Test Plan:
- Reset, then Start pulse -> Qr=1, Length=3, Locations[0..2]=88,87,86, Food=8C.
- 4 Ticks, no buttons -> head 8C after the 4th Tick. That Tick eats: Length=4, PLACE entered. Food later updates to a value not in {8C,8B,8A,89}; Qr returns.
- From head 88 moving R: assert BtnL then Tick -> direction unchanged, head=89. BtnU then Tick -> head=79.
- Drive head to col 15 moving R, then Tick -> Ql=1, Locations unchanged.
- With SNAKE_WRAP_EN: the same stimulus gives head=row*16+0, Qr=1.
- Force food on the path repeatedly until Length reaches 8 -> Qw=1. A further Tick or Btn has no effect.
- Reset asserted during PLACE -> next cycle Qi=1, Length=0, Food=00, LFSR=A5.
